multi_freq_gen: RTL and testbench

Parametrised multi-channel frequency/PWM generator, the successor to the single-channel 8-bit generator.
- Sits between the HPS-facing PIO registers and the GPIO_0 pins.
- Each channel has its own period, high time and mode, plus a shared prescaler.
- New settings go into per-channel shadow registers and are committed only at a period boundary, so outputs never glitch.
- Supports continuous PWM/square and one-shot pulse modes.

---
 rtl/freq_gen_pkg.sv | 19 +
 rtl/freq_gen_channel.sv | 123 ++++++++++++
 rtl/multi_freq_gen.sv | 59 +++++
 tb/tb_multi_freq_gen.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_gen_pkg.sv
// Shared encodings for the multi-channel frequency/PWM generator.
package freq_gen_pkg;

  // Field select values carried on wr_sel
  localparam logic [1:0] SEL_PERIOD = 2'd0;
  localparam logic [1:0] SEL_HIGH   = 2'd1;
  localparam logic [1:0] SEL_CTRL   = 2'd2;

  // Bit positions inside the CTRL field
  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;

  // Per-channel run state
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_t;

endpackage

// File: rtl/freq_gen_channel.sv
// One generator channel: shadow/active settings, period counter, run state
// and registered output. Settings only move from shadow to active at a
// period boundary or while the channel is idle, so the output never glitches.
module freq_gen_channel
  import freq_gen_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             wr_en,
  input  logic [1:0]       wr_sel,
  input  logic [DIV_W-1:0] wr_data,
  output logic             freq_out,
  output logic             wrap_pulse,
  output logic             pending,
  output logic             done
);

  ch_state_t        state, state_n;
  logic [DIV_W-1:0] period_s, period_s_n, high_s, high_s_n;
  logic [1:0]       ctrl_s, ctrl_s_n;
  logic [DIV_W-1:0] period_a, period_a_n, high_a, high_a_n;
  logic             oneshot_a, oneshot_a_n;
  logic [DIV_W-1:0] cnt, cnt_n;
  logic             pending_n, done_n, freq_n, wrap_d, wrap_d_n, wrap_pulse_n;

  logic [DIV_W-1:0] period_m, high_m;
  logic [1:0]       ctrl_m;
  logic             wrap, commit;

  // State register: every flop of the channel, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      period_s   <= '0;
      high_s     <= '0;
      ctrl_s     <= '0;
      period_a   <= '0;
      high_a     <= '0;
      oneshot_a  <= 1'b0;
      cnt        <= '0;
      pending    <= 1'b0;
      done       <= 1'b0;
      freq_out   <= 1'b0;
      wrap_d     <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      period_s   <= period_s_n;
      high_s     <= high_s_n;
      ctrl_s     <= ctrl_s_n;
      period_a   <= period_a_n;
      high_a     <= high_a_n;
      oneshot_a  <= oneshot_a_n;
      cnt        <= cnt_n;
      pending    <= pending_n;
      done       <= done_n;
      freq_out   <= freq_n;
      wrap_d     <= wrap_d_n;
      wrap_pulse <= wrap_pulse_n;
    end
  end

  // Next-state logic: merge any write into the shadow, commit the merged
  // shadow at a wrap or while idle, advance the counter on ticks
  always_comb begin
    period_m = period_s;
    high_m   = high_s;
    ctrl_m   = ctrl_s;
    if (wr_en) begin
      case (wr_sel)
        SEL_PERIOD: period_m = wr_data;
        SEL_HIGH:   high_m   = wr_data;
        SEL_CTRL:   ctrl_m   = wr_data[1:0];
        default:    ;
      endcase
    end

    wrap   = tick && (state == RUN) && (cnt == period_a);
    // A write landing on the wrap cycle is committed straight away
    commit = (wrap && (pending || wr_en)) || ((state == IDLE) && pending);

    state_n     = state;
    period_s_n  = period_m;
    high_s_n    = high_m;
    ctrl_s_n    = ctrl_m;
    period_a_n  = period_a;
    high_a_n    = high_a;
    oneshot_a_n = oneshot_a;
    pending_n   = commit ? 1'b0 : (pending || wr_en);

    if (commit) begin
      period_a_n  = period_m;
      high_a_n    = high_m;
      oneshot_a_n = ctrl_m[CTRL_ONESHOT];
      state_n     = ctrl_m[CTRL_EN] ? RUN : IDLE;
    end else if (wrap && oneshot_a) begin
      state_n = IDLE;
    end

    cnt_n = cnt;
    if (state == IDLE || wrap) begin
      cnt_n = '0;
    end else if (tick) begin
      cnt_n = cnt + 1'b1;
    end

    done_n = done;
    if (wr_en && wr_sel == SEL_CTRL) begin
      done_n = 1'b0;
    end
    if (wrap && oneshot_a) begin
      done_n = 1'b1;
    end

    freq_n       = (state == RUN) && (cnt < high_a);
    wrap_d_n     = wrap;
    wrap_pulse_n = wrap_d;
  end

endmodule

// File: rtl/multi_freq_gen.sv
// Multi-channel frequency/PWM generator: shared prescaler, write decode and
// NUM_CH independent channel instances driving the GPIO outputs.
module multi_freq_gen
  import freq_gen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 16,
  parameter int PRE_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PRE_W-1:0]  prescale,
  input  logic              wr_en,
  input  logic [3:0]        wr_ch,
  input  logic [1:0]        wr_sel,
  input  logic [DIV_W-1:0]  wr_data,
  output logic [NUM_CH-1:0] freq_out,
  output logic [NUM_CH-1:0] wrap_pulse,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] done
);

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic             wr_ok;

  assign tick  = (pre_cnt == prescale);
  assign wr_ok = wr_en && (int'(wr_ch) < NUM_CH) &&
                 (wr_sel == SEL_PERIOD || wr_sel == SEL_HIGH || wr_sel == SEL_CTRL);

  // Free-running prescaler; a prescale lowered below the count just wraps
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    freq_gen_channel #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .wr_en     (wr_ok && (wr_ch == 4'(i))),
      .wr_sel    (wr_sel),
      .wr_data   (wr_data),
      .freq_out  (freq_out[i]),
      .wrap_pulse(wrap_pulse[i]),
      .pending   (pending[i]),
      .done      (done[i])
    );
  end

endmodule

// File: tb/tb_multi_freq_gen.sv
// Directed testbench for multi_freq_gen with a queue of expected values.
module tb_multi_freq_gen;
  import freq_gen_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 16;
  localparam int PRE_W  = 8;

  localparam int F_FREQ = 0;
  localparam int F_WRAP = 1;
  localparam int F_PEND = 2;
  localparam int F_DONE = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [PRE_W-1:0]  prescale;
  logic              wr_en;
  logic [3:0]        wr_ch;
  logic [1:0]        wr_sel;
  logic [DIV_W-1:0]  wr_data;
  logic [NUM_CH-1:0] freq_out, wrap_pulse, pending, done;

  typedef struct {
    string             tag;
    int                field;
    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] val;
  } exp_t;

  exp_t sb[$];
  int   pass_count  = 0;
  int   check_count = 0;

  multi_freq_gen #(
    .NUM_CH(NUM_CH),
    .DIV_W (DIV_W),
    .PRE_W (PRE_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .prescale  (prescale),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .freq_out  (freq_out),
    .wrap_pulse(wrap_pulse),
    .pending   (pending),
    .done      (done)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  // Guard against a stuck run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [3:0] ch,
                               input logic [1:0] sel, input logic [DIV_W-1:0] data);
    wr_en   = en;
    wr_ch   = ch;
    wr_sel  = sel;
    wr_data = data;
  endtask

  task automatic expectBit(input string tag, input int field, input int ch, input logic v);
    exp_t e;
    e.tag       = tag;
    e.field     = field;
    e.mask      = '0;
    e.mask[ch]  = 1'b1;
    e.val       = '0;
    e.val[ch]   = v;
    sb.push_back(e);
  endtask

  task automatic expectVec(input string tag, input int field, input logic [NUM_CH-1:0] v);
    exp_t e;
    e.tag   = tag;
    e.field = field;
    e.mask  = '1;
    e.val   = v;
    sb.push_back(e);
  endtask

  function automatic logic [NUM_CH-1:0] fieldValue(input int field);
    case (field)
      F_FREQ:  return freq_out;
      F_WRAP:  return wrap_pulse;
      F_PEND:  return pending;
      default: return done;
    endcase
  endfunction

  task automatic checkOutput();
    exp_t e;
    logic [NUM_CH-1:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = fieldValue(e.field) & e.mask;
      check_count++;
      assert (obs === e.val) pass_count++;
      else $error("[TB] FAIL %s: observed %b expected %b", e.tag, obs, e.val);
    end
  endtask

  // Write to an idle channel: pending rises after the write, clears one clk later
  task automatic writeIdle(input logic [3:0] ch, input logic [1:0] sel,
                           input logic [DIV_W-1:0] data);
    applyStimulus(1'b1, ch, sel, data);
    expectBit($sformatf("pend_set_ch%0d", ch), F_PEND, int'(ch), 1'b1);
    step();
    applyStimulus(1'b0, 4'd0, 2'd0, '0);
    checkOutput();
    expectBit($sformatf("pend_clear_ch%0d", ch), F_PEND, int'(ch), 1'b0);
    step();
    checkOutput();
  endtask

  initial begin
    reset    = 1'b1;
    prescale = '0;
    applyStimulus(1'b0, 4'd0, 2'd0, '0);
    step();
    step();
    expectVec("rst_freq", F_FREQ, '0);
    expectVec("rst_wrap", F_WRAP, '0);
    expectVec("rst_pend", F_PEND, '0);
    expectVec("rst_done", F_DONE, '0);
    checkOutput();
    reset = 1'b0;

    // ch0 square wave: period 4 clk, high 2 clk
    writeIdle(4'd0, SEL_PERIOD, 16'd3);
    writeIdle(4'd0, SEL_HIGH, 16'd2);
    writeIdle(4'd0, SEL_CTRL, 16'd1);
    for (int t = 1; t <= 12; t++) begin
      expectBit($sformatf("sq_freq@%0d", t), F_FREQ, 0, ((t - 1) % 4) < 2);
      expectBit($sformatf("sq_wrap@%0d", t), F_WRAP, 0, (t > 1) && ((t - 1) % 4 == 0));
      step();
      checkOutput();
    end

    // ch2 one-shot: single 3-clk pulse, one wrap, sticky done
    writeIdle(4'd2, SEL_PERIOD, 16'd7);
    writeIdle(4'd2, SEL_HIGH, 16'd3);
    writeIdle(4'd2, SEL_CTRL, 16'd3);
    for (int t = 1; t <= 14; t++) begin
      expectBit($sformatf("os_freq@%0d", t), F_FREQ, 2, t <= 3);
      expectBit($sformatf("os_wrap@%0d", t), F_WRAP, 2, t == 9);
      expectBit($sformatf("os_done@%0d", t), F_DONE, 2, t >= 8);
      step();
      checkOutput();
    end

    // Invalid writes leave every channel untouched
    applyStimulus(1'b1, 4'd4, SEL_CTRL, 16'd1);
    step();
    applyStimulus(1'b0, 4'd0, 2'd0, '0);
    expectVec("badch_pend", F_PEND, '0);
    expectBit("badch_done", F_DONE, 2, 1'b1);
    checkOutput();
    applyStimulus(1'b1, 4'd3, 2'd3, 16'hFFFF);
    step();
    applyStimulus(1'b0, 4'd0, 2'd0, '0);
    expectVec("sel3_pend", F_PEND, '0);
    checkOutput();
    applyStimulus(1'b1, 4'd2, 2'd3, 16'd0);
    step();
    applyStimulus(1'b0, 4'd0, 2'd0, '0);
    expectBit("sel3_keep_done", F_DONE, 2, 1'b1);
    expectBit("sel3_freq3", F_FREQ, 3, 1'b0);
    checkOutput();
    step();
    expectVec("sel3_pend_late", F_PEND, '0);
    expectBit("sel3_freq3_late", F_FREQ, 3, 1'b0);
    checkOutput();

    // CTRL write clears done; re-arm the one-shot so done is set again
    applyStimulus(1'b1, 4'd2, SEL_CTRL, 16'd0);
    step();
    applyStimulus(1'b0, 4'd0, 2'd0, '0);
    expectBit("ctrl_clears_done", F_DONE, 2, 1'b0);
    checkOutput();
    step();
    writeIdle(4'd2, SEL_CTRL, 16'd3);
    for (int t = 1; t <= 9; t++) step();
    expectBit("rearm_done", F_DONE, 2, 1'b1);
    checkOutput();

    // ch1 with high > period at prescale 1: constant high, wrap every 10 clk
    prescale = 8'd1;
    writeIdle(4'd1, SEL_PERIOD, 16'd4);
    writeIdle(4'd1, SEL_HIGH, 16'd5);
    writeIdle(4'd1, SEL_CTRL, 16'd1);
    for (int k = 0; k < 40 && wrap_pulse[1] !== 1'b1; k++) step();
    expectBit("ch1_first_wrap", F_WRAP, 1, 1'b1);
    checkOutput();
    for (int j = 1; j <= 20; j++) begin
      expectBit($sformatf("hi_freq@%0d", j), F_FREQ, 1, 1'b1);
      expectBit($sformatf("hi_wrap@%0d", j), F_WRAP, 1, (j % 10) == 0);
      step();
      checkOutput();
    end
    // HIGH=0 mid-period only takes effect at the next wrap
    for (int j = 21; j <= 34; j++) begin
      if (j == 21) applyStimulus(1'b1, 4'd1, SEL_HIGH, 16'd0);
      expectBit($sformatf("lo_freq@%0d", j), F_FREQ, 1, j < 30);
      expectBit($sformatf("lo_pend@%0d", j), F_PEND, 1, j < 29);
      expectBit($sformatf("lo_wrap@%0d", j), F_WRAP, 1, j == 30);
      step();
      applyStimulus(1'b0, 4'd0, 2'd0, '0);
      checkOutput();
    end

    // Reset mid-period with a pending shadow and a sticky done
    applyStimulus(1'b1, 4'd1, SEL_PERIOD, 16'd2);
    expectBit("prerst_pend", F_PEND, 1, 1'b1);
    step();
    applyStimulus(1'b0, 4'd0, 2'd0, '0);
    checkOutput();
    reset    = 1'b1;
    prescale = '0;
    expectVec("midrst_freq", F_FREQ, '0);
    expectVec("midrst_wrap", F_WRAP, '0);
    expectVec("midrst_pend", F_PEND, '0);
    expectVec("midrst_done", F_DONE, '0);
    step();
    reset = 1'b0;
    checkOutput();
    for (int t = 1; t <= 6; t++) begin
      expectVec($sformatf("idle_freq@%0d", t), F_FREQ, '0);
      expectVec($sformatf("idle_pend@%0d", t), F_PEND, '0);
      step();
      checkOutput();
    end

    // ch0 period change mid-period, then a write on the wrap cycle
    writeIdle(4'd0, SEL_PERIOD, 16'd9);
    writeIdle(4'd0, SEL_HIGH, 16'd5);
    writeIdle(4'd0, SEL_CTRL, 16'd1);
    for (int t = 1; t <= 24; t++) begin
      logic ef;
      if (t == 3)  applyStimulus(1'b1, 4'd0, SEL_PERIOD, 16'd3);
      if (t == 18) applyStimulus(1'b1, 4'd0, SEL_HIGH, 16'd2);
      if (t <= 5)       ef = 1'b1;
      else if (t <= 10) ef = 1'b0;
      else if (t <= 18) ef = 1'b1;
      else              ef = ((t - 19) % 4) < 2;
      expectBit($sformatf("chg_freq@%0d", t), F_FREQ, 0, ef);
      expectBit($sformatf("chg_wrap@%0d", t), F_WRAP, 0,
                t == 11 || t == 15 || t == 19 || t == 23);
      expectBit($sformatf("chg_pend@%0d", t), F_PEND, 0, t >= 3 && t <= 9);
      step();
      applyStimulus(1'b0, 4'd0, 2'd0, '0);
      checkOutput();
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
